// File: rtl/ed_tagged_stream_decoder.sv
// ---------------------------------------------------------------------------
// ed_tagged_stream_decoder
//
// Receive side of the energy-detection tagged stream. Every input word is
// {det_flag, sample[DATA_W-2:0]}. The decoder does four things:
//    - cuts the stream into windows of window_size words;
//    - restores the sample by sign-extending bit DATA_W-2 into the MSB;
//    - latches one detection flag per window and pulses start/end events;
//    - counts the windows that ended with the flag set.
//
// Optional feature (compile-time macro ED_DEC_GATE_EN):
//    When the macro is defined, words that belong to a window whose flag is
//    0 are still accepted and consumed, but they are never loaded into the
//    output register. The window events and det_count work as normal.
//    When the macro is undefined, every accepted word is forwarded.
//
// Parameters:
//    DATA_W     tagged word width; the MSB is the detection flag
//    CNT_W      window position counter width (window_size 0 = 2^CNT_W)
//    EVT_CNT_W  detected-window counter width (saturating)
//
// Ports:
//    clock        single clock, rising edge
//    rst          asynchronous active-high reset
//    xk_d_fct_dt  tagged input word
//    din_valid    input word valid
//    din_ready    decoder can accept a word
//    window_size  words per window, sampled only at a window start
//    clr_stats    synchronous clear of det_count and flag_err
//    dout         restored sample
//    dout_valid   dout holds a word
//    dout_ready   downstream accepts dout
//    dout_last    dout is the last word of its window
//    win_start    1-cycle pulse: first word of a window accepted
//    win_end      1-cycle pulse: last word of a window accepted
//    win_det      flag of the current/last window
//    det_count    number of windows that ended with the flag set
//    flag_err     sticky: the flag changed inside a window
// ---------------------------------------------------------------------------
module ed_tagged_stream_decoder #(
   parameter int DATA_W    = 32,
   parameter int CNT_W     = 10,
   parameter int EVT_CNT_W = 16
) (
   input  logic                 clock,
   input  logic                 rst,
   input  logic [DATA_W-1:0]    xk_d_fct_dt,
   input  logic                 din_valid,
   output logic                 din_ready,
   input  logic [CNT_W-1:0]     window_size,
   input  logic                 clr_stats,
   output logic [DATA_W-1:0]    dout,
   output logic                 dout_valid,
   input  logic                 dout_ready,
   output logic                 dout_last,
   output logic                 win_start,
   output logic                 win_end,
   output logic                 win_det,
   output logic [EVT_CNT_W-1:0] det_count,
   output logic                 flag_err
);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_IN_WIN = 1'b1
   } state_t;

   // Window lengths need one extra bit so that window_size = 0 can stand
   // for the full 2^CNT_W words.
   localparam logic [CNT_W:0]     LEN_ONE = (CNT_W+1)'(1);
   localparam logic [CNT_W:0]     LEN_MAX = {1'b1, {CNT_W{1'b0}}};
   localparam logic [EVT_CNT_W-1:0] CNT_ONE = EVT_CNT_W'(1);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t                 state_reg;
   logic [CNT_W:0]         pos_reg;
   logic [CNT_W:0]         win_len_reg;
   logic                   ready_en_reg;
   logic                   out_full_reg;
   logic [DATA_W-1:0]      dout_reg;
   logic                   dout_last_reg;
   logic                   win_start_reg;
   logic                   win_end_reg;
   logic                   win_det_reg;
   logic [EVT_CNT_W-1:0]   det_count_reg;
   logic                   flag_err_reg;

   // ------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------
   logic                   in_flag;
   logic                   accept;
   logic [CNT_W:0]         first_len;
   logic [CNT_W:0]         pos_inc;
   logic                   end_now;
   logic                   win_flag;
   logic                   forward;
   logic [DATA_W-1:0]      restored;

   assign in_flag = xk_d_fct_dt[DATA_W-1];

   // ready_en_reg keeps din_ready low through reset and the first edge
   // after it; afterwards the only thing holding off input is a full,
   // stalled output register. din_valid never feeds din_ready.
   assign din_ready = ready_en_reg && (!out_full_reg || dout_ready);
   assign accept    = din_valid && din_ready;

   assign first_len = (window_size == '0) ? LEN_MAX : {1'b0, window_size};
   assign pos_inc   = pos_reg + LEN_ONE;

   // A window ends on the accepted word that brings the position up to the
   // latched length. A one-word window starts and ends in IDLE.
   always_comb begin
      end_now  = 1'b0;
      win_flag = win_det_reg;
      if (state_reg == ST_IDLE) begin
         end_now  = accept && (first_len == LEN_ONE);
         win_flag = in_flag;
      end else begin
         end_now  = accept && (pos_inc == win_len_reg);
      end
   end

`ifdef ED_DEC_GATE_EN
   // Words of undetected windows are consumed but never reach dout. The
   // first word is judged by its own flag, which is the window flag.
   assign forward = accept && win_flag;
`else
   assign forward = accept;
`endif

   // Restore the sample: the flag position is replaced by a copy of the
   // sample's top bit.
   genvar gi;
   generate
      for (gi = 0; gi < DATA_W; gi++) begin : g_restore
         if (gi == DATA_W-1) begin : g_sign
            assign restored[gi] = xk_d_fct_dt[DATA_W-2];
         end else begin : g_bit
            assign restored[gi] = xk_d_fct_dt[gi];
         end
      end
   endgenerate

   // ------------------------------------------------------------------
   // Window FSM, output register and statistics
   // ------------------------------------------------------------------
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         pos_reg       <= '0;
         win_len_reg   <= '0;
         ready_en_reg  <= 1'b0;
         out_full_reg  <= 1'b0;
         dout_reg      <= '0;
         dout_last_reg <= 1'b0;
         win_start_reg <= 1'b0;
         win_end_reg   <= 1'b0;
         win_det_reg   <= 1'b0;
         det_count_reg <= '0;
         flag_err_reg  <= 1'b0;
      end else begin
         ready_en_reg  <= 1'b1;
         win_start_reg <= 1'b0;
         win_end_reg   <= 1'b0;

         // One-deep output register. A load can only happen when the old
         // word is gone or leaving this cycle, so a stalled word is never
         // overwritten.
         if (forward) begin
            dout_reg      <= restored;
            dout_last_reg <= end_now;
            out_full_reg  <= 1'b1;
         end else if (dout_ready) begin
            out_full_reg  <= 1'b0;
         end

         if (accept) begin
            case (state_reg)
               ST_IDLE: begin
                  win_len_reg   <= first_len;
                  win_det_reg   <= in_flag;
                  win_start_reg <= 1'b1;
                  if (end_now) begin
                     win_end_reg <= 1'b1;
                     pos_reg     <= '0;
                  end else begin
                     pos_reg     <= LEN_ONE;
                     state_reg   <= ST_IN_WIN;
                  end
               end
               ST_IN_WIN: begin
                  // The window keeps the flag of its first word; a later
                  // disagreement is only reported.
                  if (in_flag != win_det_reg) begin
                     flag_err_reg <= 1'b1;
                  end
                  if (end_now) begin
                     win_end_reg <= 1'b1;
                     pos_reg     <= '0;
                     state_reg   <= ST_IDLE;
                  end else begin
                     pos_reg     <= pos_inc;
                  end
               end
               default: begin
                  state_reg <= ST_IDLE;
                  pos_reg   <= '0;
               end
            endcase
         end

         // A clear beats both a window ending this cycle and a flag error
         // found this cycle.
         if (clr_stats) begin
            det_count_reg <= '0;
            flag_err_reg  <= 1'b0;
         end else if (end_now && win_flag && (det_count_reg != '1)) begin
            det_count_reg <= det_count_reg + CNT_ONE;
         end
      end
   end

   assign dout       = dout_reg;
   assign dout_valid = out_full_reg;
   assign dout_last  = dout_last_reg;
   assign win_start  = win_start_reg;
   assign win_end    = win_end_reg;
   assign win_det    = win_det_reg;
   assign det_count  = det_count_reg;
   assign flag_err   = flag_err_reg;

endmodule
